// File: rtl/pe_sched.sv
// pe_sched: two-requester round-robin issue scheduler for a fixed-latency PE,
// with credit-limited issue, a matched tag pipeline for responses and a drain/halt FSM.
module pe_sched #(
    parameter  int unsigned PE_DELAY     = 10,
    parameter  int unsigned MAX_INFLIGHT = 8,
    localparam int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [3:0]    req0_a,
    input  logic [3:0]    req0_b,
    input  logic [3:0]    req1_a,
    input  logic [3:0]    req1_b,
    output logic [3:0]    pe_in_1,
    output logic [3:0]    pe_in_2,
    input  logic [3:0]    pe_out_1,
    input  logic [3:0]    pe_out_2,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [3:0]    rsp_r1,
    output logic [3:0]    rsp_r2,
    input  logic          drain,
    output logic          idle,
    output logic [CW-1:0] inflight
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [3:0]      pe_in_1_q, pe_in_1_d, pe_in_2_q, pe_in_2_d;
    logic [PE_DELAY:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [3:0]      rsp_r1_q, rsp_r1_d, rsp_r2_q, rsp_r2_d;

    logic issue_ok, gnt0, gnt1, accept, rsp_done;

    // Grant selection and combinational ready; drain and reset gate issue immediately
    always_comb begin
        issue_ok   = (state_q == ST_RUN) && !drain && !rstn &&
                     (inflight_q < CW'(MAX_INFLIGHT));
        gnt1       = req1_valid && (!req0_valid || !last_q);
        gnt0       = req0_valid && !gnt1;
        req0_ready = issue_ok && gnt0;
        req1_ready = issue_ok && gnt1;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        rsp_done   = tag_v_q[PE_DELAY];
    end

    // Next-state: FSM, pointer, credit counter, PE drive, tag shift and response capture
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        inflight_d  = inflight_q;
        pe_in_1_d   = 4'(0);
        pe_in_2_d   = 4'(0);
        tag_v_d     = '0;
        tag_id_d    = '0;
        rsp_valid_d = rsp_done;
        rsp_id_d    = 1'b0;
        rsp_r1_d    = 4'(0);
        rsp_r2_d    = 4'(0);

        unique case (state_q)
            ST_RUN:   if (drain) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == CW'(0)) state_d = ST_HALT;
            ST_HALT:  if (!drain) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (accept) begin
            last_d    = gnt1;
            pe_in_1_d = gnt1 ? req1_a : req0_a;
            pe_in_2_d = gnt1 ? req1_b : req0_b;
        end

        unique case ({accept, rsp_done})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        tag_v_d[0]  = accept;
        tag_id_d[0] = gnt1;
        for (int i = 1; i <= int'(PE_DELAY); i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end

        if (rsp_done) begin
            rsp_id_d = tag_id_q[PE_DELAY];
            rsp_r1_d = pe_out_1;
            rsp_r2_d = pe_out_2;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= ST_RUN;
            last_q      <= 1'b1;
            inflight_q  <= '0;
            pe_in_1_q   <= '0;
            pe_in_2_q   <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_r1_q    <= '0;
            rsp_r2_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            inflight_q  <= inflight_d;
            pe_in_1_q   <= pe_in_1_d;
            pe_in_2_q   <= pe_in_2_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r1_q    <= rsp_r1_d;
            rsp_r2_q    <= rsp_r2_d;
        end
    end

    // Output mapping from registers
    assign pe_in_1   = pe_in_1_q;
    assign pe_in_2   = pe_in_2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r1    = rsp_r1_q;
    assign rsp_r2    = rsp_r2_q;
    assign inflight  = inflight_q;
    assign idle      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pe_sched.sv
// tb_pe_sched: directed + randomized bench for pe_sched against a transaction-level model.
module tb_pe_sched;

    localparam int unsigned PE_DELAY     = 10;
    localparam int unsigned MAX_INFLIGHT = 8;
    localparam int unsigned LAT          = PE_DELAY + 2;
    localparam int unsigned CW           = $clog2(MAX_INFLIGHT + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]    req0_a, req0_b, req1_a, req1_b;
    logic [3:0]    pe_in_1, pe_in_2, pe_out_1, pe_out_2;
    logic          rsp_valid, rsp_id;
    logic [3:0]    rsp_r1, rsp_r2;
    logic          drain, idle;
    logic [CW-1:0] inflight;

    pe_sched #(.PE_DELAY(PE_DELAY), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .pe_in_1(pe_in_1), .pe_in_2(pe_in_2),
        .pe_out_1(pe_out_1), .pe_out_2(pe_out_2),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r1(rsp_r1), .rsp_r2(rsp_r2),
        .drain(drain), .idle(idle), .inflight(inflight)
    );

    // PE model: pure delay of PE_DELAY cycles from its inputs to its outputs
    logic [3:0] pe_p1 [PE_DELAY];
    logic [3:0] pe_p2 [PE_DELAY];
    always @(posedge clk) begin
        pe_p1[0] <= pe_in_1;
        pe_p2[0] <= pe_in_2;
        for (int i = 1; i < int'(PE_DELAY); i++) begin
            pe_p1[i] <= pe_p1[i-1];
            pe_p2[i] <= pe_p2[i-1];
        end
    end
    assign pe_out_1 = pe_p1[PE_DELAY-1];
    assign pe_out_2 = pe_p2[PE_DELAY-1];

    // Reference model: list of accepted operations with their accept cycle
    typedef struct {
        int       t;
        bit       id;
        bit [3:0] a;
        bit [3:0] b;
    } op_t;

    op_t q[$];
    int  cyc;
    int  mode;      // 0 run, 1 draining, 2 halted
    bit  last;      // requester served last
    int  total, bad;

    // Outstanding = accepted before this cycle whose credit has not yet returned
    function automatic int m_inflight();
        int n = 0;
        foreach (q[i]) if (q[i].t < cyc && q[i].t + int'(LAT) - 1 >= cyc) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic step();
        int  inf;
        bit  e_r0, e_r1, e_rv, e_id, g1;
        bit [3:0] e_a, e_b;
        #1;
        inf  = m_inflight();
        e_r0 = 0; e_r1 = 0; e_rv = 0; e_id = 0; e_a = 0; e_b = 0;
        g1   = req1_valid && (!req0_valid || !last);
        if (!rstn && mode == 0 && !drain && inf < int'(MAX_INFLIGHT) &&
            (req0_valid || req1_valid)) begin
            if (g1) e_r1 = 1; else e_r0 = 1;
        end
        foreach (q[i]) if (q[i].t + int'(LAT) == cyc) begin
            e_rv = 1; e_id = q[i].id; e_a = q[i].a; e_b = q[i].b;
        end
        chk("ready0",    int'(req0_ready), int'(e_r0));
        chk("ready1",    int'(req1_ready), int'(e_r1));
        chk("rsp_valid", int'(rsp_valid),  int'(e_rv));
        chk("rsp_id",    int'(rsp_id),     int'(e_id));
        chk("rsp_r1",    int'(rsp_r1),     int'(e_a));
        chk("rsp_r2",    int'(rsp_r2),     int'(e_b));
        chk("inflight",  int'(inflight),   inf);
        chk("idle",      int'(idle),       int'(mode == 2));
        chk("credit_cap", int'(inflight <= CW'(MAX_INFLIGHT)), 1);

        if (rstn) begin
            mode = 0; last = 1; q.delete();
        end else begin
            if (e_r0 && req0_valid) begin q.push_back('{cyc, 1'b0, req0_a, req0_b}); last = 0; end
            if (e_r1 && req1_valid) begin q.push_back('{cyc, 1'b1, req1_a, req1_b}); last = 1; end
            case (mode)
                0: if (drain) mode = 1;
                1: if (inf == 0) mode = 2;
                default: if (!drain) mode = 0;
            endcase
        end
        @(posedge clk);
        cyc++;
        while (q.size() > 0 && q[0].t + int'(LAT) < cyc) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic rand_ops();
        req0_a = 4'($urandom); req0_b = 4'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; mode = 0; last = 1;
        rstn = 1; drain = 0; req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        repeat (PE_DELAY + 3) @(posedge clk);
        @(negedge clk);
        rstn = 0;

        // Reset state and single issue: a=3, b=5 from req0
        step();
        req0_valid = 1; req0_a = 4'd3; req0_b = 4'd5;
        step();
        req0_valid = 0;
        repeat (LAT + 2) step();

        // Contention: both valid continuously, grants alternate
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
        req0_valid = 0; req1_valid = 0;
        repeat (LAT + 2) step();

        // Credit limit: req0 alone, continuously valid
        req0_valid = 1;
        for (int i = 0; i < 24; i++) begin rand_ops(); step(); end
        req0_valid = 0;
        repeat (LAT + 2) step();

        // Drain with 5 in flight, then resume
        req0_valid = 1;
        for (int i = 0; i < 20 && m_inflight() < 5; i++) begin rand_ops(); step(); end
        chk("drain_setup", m_inflight(), 5);
        drain = 1; req1_valid = 1;
        repeat (LAT + 4) begin rand_ops(); step(); end
        chk("drain_halted", int'(idle), 1);
        drain = 0;
        repeat (LAT + 4) begin rand_ops(); step(); end
        req0_valid = 0; req1_valid = 0;
        repeat (LAT + 2) step();

        // Randomized traffic with occasional drain toggles
        for (int i = 0; i < 300; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) drain = ~drain;
            rand_ops();
            step();
        end
        drain = 0; req0_valid = 0; req1_valid = 0;
        repeat (LAT + 4) step();

        // Reset mid-stream with 4 in flight
        req0_valid = 1;
        for (int i = 0; i < 20 && m_inflight() < 4; i++) begin rand_ops(); step(); end
        chk("rst_setup", m_inflight(), 4);
        rstn = 1; req1_valid = 1;
        step();
        rstn = 0; req0_valid = 0; req1_valid = 0;
        repeat (14) step();
        req0_valid = 1; req1_valid = 1; rand_ops();
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (LAT + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_sched.md
PE_SCHED -- requirements
Module: pe_sched

Interface
REQ-001 SHALL have parameter PE_DELAY, default 10, meaning the DELAY_CYCLES setting of the attached PE.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8, meaning the outstanding-operation limit, legal range 1..PE_DELAY+2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-high: rstn=1 at a posedge resets the block.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester has an operand pair.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  pair accepted this cycle when valid&ready.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  operand pair per requester.
REQ-008 SHALL have ports pe_in_1, pe_in_2  output  4  registered drive to the PE inputs.
REQ-009 SHALL have ports pe_out_1, pe_out_2  input  4  PE outputs.
REQ-010 SHALL have ports rsp_valid  output  1,  rsp_id  output  1,  rsp_r1/rsp_r2  output  4  result return.
REQ-011 SHALL have port drain  input  1  request to stop issuing and empty the PE.
REQ-012 SHALL have ports idle  output  1  (halted and empty) and inflight  output  clog2(MAX_INFLIGHT+1)  outstanding count.

Function
REQ-013 SHALL run FSM states RUN, DRAIN, HALT; issue is permitted only in RUN with drain=0.
REQ-014 SHALL transition RUN->DRAIN when drain=1; DRAIN->HALT when inflight==0; HALT->RUN when drain=0; otherwise hold state.
REQ-015 SHALL arbitrate round-robin: a single valid requester is granted; when both are valid, the requester not served last is granted.
REQ-016 SHALL update the last-served pointer only on an accepted issue.
REQ-017 SHALL assert reqN_ready combinationally iff issue is permitted, inflight<MAX_INFLIGHT, and N is granted; at most one ready per cycle.
REQ-018 SHALL register pe_in_1/pe_in_2 <= granted a/b at the accepting edge, else <= 0.
REQ-019 SHALL carry a (valid,id) tag through a shift pipeline matched to the PE so that a pair accepted in cycle t produces rsp_valid=1 in cycle t+PE_DELAY+2.
REQ-020 SHALL drive rsp_id = tag id, rsp_r1 = pe_out_1, rsp_r2 = pe_out_2 when rsp_valid=1, and all three = 0 otherwise.
REQ-021 SHALL not apply backpressure to responses; a response is delivered in exactly one cycle.
REQ-022 SHALL update inflight +1 on issue, -1 on response, and leave it unchanged on both in the same cycle; it never exceeds MAX_INFLIGHT or underflows.
REQ-023 SHALL sustain one issue per cycle when inflight<MAX_INFLIGHT, including back-to-back issues from one requester if the other is idle.
REQ-024 SHALL assert idle=1 iff state==HALT.
REQ-025 SHALL block issue in the cycle drain is first sampled high (ready gated by drain directly).

Reset
REQ-026 SHALL on rstn=1 clear all tags, inflight=0, pe_in_*=0, rsp_*=0, state=RUN, and last-served=req1 so req0 wins the first tie.
REQ-027 SHALL on reset mid-operation discard all in-flight tags and emit no response for them, regardless of pe_out values.
REQ-028 SHALL hold all ready outputs at 0 while rstn=1.

Verification (PE_DELAY=10, MAX_INFLIGHT=8, PE model wired, latency 12)
REQ-029 SHALL check single issue: req0 a=3, b=5 accepted in cycle 0 -> rsp_valid=1, id=0, r1=3, r2=5 in cycle 12 only; inflight goes 1 then back to 0.
REQ-030 SHALL check contention: both valid continuously -> grants alternate 0,1,0,1...; responses return in the same order with matching ids.
REQ-031 SHALL check credit limit: req0 valid continuously -> 8 issues in cycles 0-7, ready=0 in cycles 8-11, issue resumes in cycle 12 with the first response; inflight never exceeds 8.
REQ-032 SHALL check drain: drain=1 with 5 in flight -> no ready from that cycle, all 5 responses arrive, HALT and idle=1 after inflight reaches 0; drain=0 -> RUN and issue resumes.
REQ-033 SHALL check reset mid-stream: rstn=1 for one cycle with 4 in flight -> rsp_valid stays 0 for the next 14 cycles, inflight=0, and the first tie after reset is granted to req0.
